comparador_bcd_ctrl: RTL and testbench

//  Sequencer for the millisecond counter's target-match check. It shares one
//  4-bit equality comparator across all BCD digits of the counter value and a

---
 rtl/comparador_pkg.sv | 12 +
 rtl/igualdad_4b.sv | 18 +
 rtl/comparador_bcd_ctrl.sv | 128 ++++++++++++
 tb/tb_comparador_bcd_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparador_pkg.sv
// Shared definitions for the BCD target-match sequencer: FSM state encoding and digit width.
package comparador_pkg;

  localparam int ANCHO_DIG = 4;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    COMPARA = 2'd1,
    FIN     = 2'd2
  } estado_t;

endpackage

// File: rtl/igualdad_4b.sv
// Shared single-digit comparator: a==b, plus a>b when MAGNITUD_EN is defined.
module igualdad_4b
  import comparador_pkg::*;
(
  input  logic [ANCHO_DIG-1:0] a,
  input  logic [ANCHO_DIG-1:0] b,
`ifdef MAGNITUD_EN
  output logic                 gt,
`endif
  output logic                 eq
);

  assign eq = (a == b);
`ifdef MAGNITUD_EN
  assign gt = (a > b);
`endif

endmodule

// File: rtl/comparador_bcd_ctrl.sv
// Digit-serial equality check of counter value vs target, MSB first with early exit.
// Optional magnitude output enabled by defining MAGNITUD_EN.
module comparador_bcd_ctrl
  import comparador_pkg::*;
#(
  parameter int N_DIGITOS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [N_DIGITOS*ANCHO_DIG-1:0] valor,
  input  logic [N_DIGITOS*ANCHO_DIG-1:0] objetivo,
  output logic                           busy,
  output logic                           done,
`ifdef MAGNITUD_EN
  output logic                           mayor,
`endif
  output logic                           igual
);

  localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int ANCHO = N_DIGITOS * ANCHO_DIG;

  estado_t          estado_reg, estado_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [ANCHO-1:0] valor_reg, valor_next;
  logic [ANCHO-1:0] objetivo_reg, objetivo_next;
  logic             igual_reg, igual_next;
  logic             dig_eq;

  logic [ANCHO_DIG-1:0] dig_v [N_DIGITOS];
  logic [ANCHO_DIG-1:0] dig_o [N_DIGITOS];

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITOS; gi++) begin : g_digitos
      assign dig_v[gi] = valor_reg[gi*ANCHO_DIG +: ANCHO_DIG];
      assign dig_o[gi] = objetivo_reg[gi*ANCHO_DIG +: ANCHO_DIG];
    end
  endgenerate

`ifdef MAGNITUD_EN
  logic mayor_reg, mayor_next;
  logic dig_gt;

  igualdad_4b u_cmp (
    .a  (dig_v[idx_reg]),
    .b  (dig_o[idx_reg]),
    .gt (dig_gt),
    .eq (dig_eq)
  );
  assign mayor = mayor_reg;
`else
  igualdad_4b u_cmp (
    .a  (dig_v[idx_reg]),
    .b  (dig_o[idx_reg]),
    .eq (dig_eq)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_reg   <= REPOSO;
      idx_reg      <= '0;
      valor_reg    <= '0;
      objetivo_reg <= '0;
      igual_reg    <= 1'b0;
`ifdef MAGNITUD_EN
      mayor_reg    <= 1'b0;
`endif
    end else begin
      estado_reg   <= estado_next;
      idx_reg      <= idx_next;
      valor_reg    <= valor_next;
      objetivo_reg <= objetivo_next;
      igual_reg    <= igual_next;
`ifdef MAGNITUD_EN
      mayor_reg    <= mayor_next;
`endif
    end
  end

  always_comb begin
    estado_next   = estado_reg;
    idx_next      = idx_reg;
    valor_next    = valor_reg;
    objetivo_next = objetivo_reg;
    igual_next    = igual_reg;
`ifdef MAGNITUD_EN
    mayor_next    = mayor_reg;
`endif
    case (estado_reg)
      REPOSO: begin
        if (start) begin
          valor_next    = valor;
          objetivo_next = objetivo;
          idx_next      = IDX_W'(N_DIGITOS - 1);
          estado_next   = COMPARA;
        end
      end
      COMPARA: begin
        // First unequal digit from the MSB side decides both results.
        if (!dig_eq) begin
          igual_next  = 1'b0;
`ifdef MAGNITUD_EN
          mayor_next  = dig_gt;
`endif
          estado_next = FIN;
        end else if (idx_reg == '0) begin
          igual_next  = 1'b1;
`ifdef MAGNITUD_EN
          mayor_next  = 1'b0;
`endif
          estado_next = FIN;
        end else begin
          idx_next = idx_reg - IDX_W'(1);
        end
      end
      FIN:     estado_next = REPOSO;
      default: estado_next = REPOSO;
    endcase
  end

  assign busy  = (estado_reg == COMPARA);
  assign done  = (estado_reg == FIN);
  assign igual = igual_reg;

endmodule

// File: tb/tb_comparador_bcd_ctrl.sv
// Directed self-checking bench for comparador_bcd_ctrl (4 digits); mayor checks only under MAGNITUD_EN.
module tb_comparador_bcd_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] valor;
  logic [15:0] objetivo;
  logic        busy;
  logic        done;
  logic        igual;
  logic        mayor;

  int checks;
  int failures;

  comparador_bcd_ctrl #(.N_DIGITOS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .valor    (valor),
    .objetivo (objetivo),
    .busy     (busy),
    .done     (done),
`ifdef MAGNITUD_EN
    .mayor    (mayor),
`endif
    .igual    (igual)
  );

`ifndef MAGNITUD_EN
  assign mayor = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from REPOSO and returns in the done cycle (or after the bound).
  task automatic do_op(input logic [15:0] v, input logic [15:0] o, input logic [15:0] v_after,
                       output int done_cyc, output int busy_cyc);
    valor = v;
    objetivo = o;
    start = 1'b1;
    tick();
    start = 1'b0;
    valor = v_after;
    done_cyc = -1;
    busy_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    valor = 16'h0999;
    objetivo = 16'h0999;
    tick();
    tick();
    checks++;
    if ({busy, done, igual, mayor} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs busy/done/igual/mayor got=%b want=0000", {busy, done, igual, mayor});
    end
    #3 rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_compara busy got=%b want=1", busy);
    end
    start = 1'b0;
    for (int c = 0; c < 20 && !done; c++) tick();
    checks++;
    if (done !== 1'b1 || igual !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_op done=%b igual=%b want done=1 igual=1", done, igual);
    end
    tick();
    $display("txn reset: released, first op igual=%b", igual);
  endtask

  task automatic test_full_match();
    int dc, bc;
    do_op(16'h0999, 16'h0999, 16'h0999, dc, bc);
    checks++;
    if (dc !== 5) begin failures++; $display("FAIL match_done_cycle got=%0d want=5", dc); end
    checks++;
    if (bc !== 4) begin failures++; $display("FAIL match_busy_cycles got=%0d want=4", bc); end
    checks++;
    if (igual !== 1'b1 || mayor !== 1'b0) begin
      failures++;
      $display("FAIL match_result igual=%b mayor=%b want igual=1 mayor=0", igual, mayor);
    end
    tick();
    checks++;
    if (done !== 1'b0 || igual !== 1'b1) begin
      failures++;
      $display("FAIL match_pulse_hold done=%b igual=%b want done=0 igual=1", done, igual);
    end
    $display("txn full_match 0999/0999: done_cycle=%0d busy=%0d igual=%b", dc, bc, igual);
  endtask

  task automatic test_msb_mismatch();
    int dc, bc;
    do_op(16'h1000, 16'h0999, 16'h1000, dc, bc);
    checks++;
    if (dc !== 2) begin failures++; $display("FAIL msb_done_cycle got=%0d want=2", dc); end
    checks++;
    if (igual !== 1'b0) begin failures++; $display("FAIL msb_igual got=%b want=0", igual); end
`ifdef MAGNITUD_EN
    checks++;
    if (mayor !== 1'b1) begin failures++; $display("FAIL msb_mayor got=%b want=1", mayor); end
`endif
    tick();
    $display("txn msb_mismatch 1000/0999: done_cycle=%0d igual=%b mayor=%b", dc, igual, mayor);
  endtask

  task automatic test_lsb_mismatch();
    int dc, bc;
    // Operand changes after the start edge must not affect the result.
    do_op(16'h0998, 16'h0999, 16'h0999, dc, bc);
    checks++;
    if (dc !== 5) begin failures++; $display("FAIL lsb_done_cycle got=%0d want=5", dc); end
    checks++;
    if (igual !== 1'b0 || mayor !== 1'b0) begin
      failures++;
      $display("FAIL lsb_result igual=%b mayor=%b want igual=0 mayor=0", igual, mayor);
    end
    tick();
    $display("txn lsb_mismatch 0998/0999: done_cycle=%0d igual=%b", dc, igual);
    do_op(16'h0989, 16'h0999, 16'h0989, dc, bc);
    checks++;
    if (dc !== 4) begin failures++; $display("FAIL digit1_done_cycle got=%0d want=4", dc); end
    tick();
    $display("txn digit1_mismatch 0989/0999: done_cycle=%0d", dc);
    do_op(16'h000A, 16'h0009, 16'h000A, dc, bc);
    checks++;
    if (dc !== 5 || igual !== 1'b0) begin
      failures++;
      $display("FAIL nonbcd_result done_cycle=%0d igual=%b want 5/0", dc, igual);
    end
`ifdef MAGNITUD_EN
    checks++;
    if (mayor !== 1'b1) begin failures++; $display("FAIL nonbcd_mayor got=%b want=1", mayor); end
`endif
    tick();
    $display("txn nonbcd 000A/0009: done_cycle=%0d igual=%b mayor=%b", dc, igual, mayor);
  endtask

  task automatic test_hold();
    int dc, bc;
    do_op(16'h1234, 16'h1234, 16'h1234, dc, bc);
    tick();
    valor = 16'h1235;
    objetivo = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || igual !== 1'b1) begin
      failures++;
      $display("FAIL hold_during_busy busy=%b igual=%b want busy=1 igual=1", busy, igual);
    end
    for (int c = 0; c < 20 && !done; c++) tick();
    checks++;
    if (igual !== 1'b0) begin failures++; $display("FAIL hold_update igual got=%b want=0", igual); end
    tick();
    $display("txn hold 1234 then 1235/1234: igual=%b", igual);
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    valor = 16'h0999;
    objetivo = 16'h0999;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      start = (c >= 2 && c <= 5);
      if (done) dones++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (dones !== 1) begin failures++; $display("FAIL ignored_start dones got=%0d want=1", dones); end
    $display("txn ignored_start: dones=%0d", dones);
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int first = -1;
    int second = -1;
    logic idle_ok = 1'b1;
    valor = 16'h1000;
    objetivo = 16'h0999;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 9; c++) begin
      if (done) begin
        dones++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (c == 3 && (busy !== 1'b0 || done !== 1'b0)) idle_ok = 1'b0;
      tick();
    end
    start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (dones !== 3 || first !== 2 || second !== 5) begin
      failures++;
      $display("FAIL back_to_back dones=%0d first=%0d second=%0d want 3/2/5", dones, first, second);
    end
    checks++;
    if (idle_ok !== 1'b1) begin failures++; $display("FAIL back_to_back_reposo got=0 want=1"); end
    $display("txn back_to_back: dones=%0d first=%0d second=%0d", dones, first, second);
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    int dc, bc;
    do_op(16'h0999, 16'h0999, 16'h0999, dc, bc);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, igual} !== 3'b000) begin
      failures++;
      $display("FAIL abort_immediate busy/done/igual got=%b want=000", {busy, done, igual});
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) dones++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL abort_no_done dones got=%0d want=0", dones); end
    $display("txn reset_abort: dones=%0d igual=%b", dones, igual);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    valor = '0;
    objetivo = '0;
    test_reset();
    test_full_match();
    test_msb_mismatch();
    test_lsb_mismatch();
    test_hold();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
